// File: rtl/memory_controller_pkg.sv
// memory_controller_pkg
//   Shared widths, memory op encodings and controller state codes for the
//   memory controller and its neighbours (LSB, ROB, IF).
package memory_controller_pkg;

    localparam int XLEN           = 32;
    localparam int INST_OP_WIDTH  = 6;
    localparam int ROB_SIZE_WIDTH = 4;

    localparam logic [INST_OP_WIDTH-1:0] OP_LB  = 6'd11;
    localparam logic [INST_OP_WIDTH-1:0] OP_LH  = 6'd12;
    localparam logic [INST_OP_WIDTH-1:0] OP_LW  = 6'd13;
    localparam logic [INST_OP_WIDTH-1:0] OP_LBU = 6'd14;
    localparam logic [INST_OP_WIDTH-1:0] OP_LHU = 6'd15;
    localparam logic [INST_OP_WIDTH-1:0] OP_SB  = 6'd16;
    localparam logic [INST_OP_WIDTH-1:0] OP_SH  = 6'd17;
    localparam logic [INST_OP_WIDTH-1:0] OP_SW  = 6'd18;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_LOAD  = 2'd1,
        MC_STORE = 2'd2,
        MC_FETCH = 2'd3
    } mc_state_e;

    // Number of bytes moved on the RAM port for a given op.
    function automatic logic [2:0] op_len(input logic [INST_OP_WIDTH-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_controller.sv
// memory_controller
//   Sole owner of the byte-wide RAM/IO port. Serialises committed stores
//   (ROB), loads (LSB) and 32-bit instruction fetches (IF), priority
//   store > load > fetch, accepting only when idle.
// Ports:
//   clk, rst (sync, active high), rdy (global enable), flush
//   io_buffer_full              : hold stores to the IO port while set
//   lsb_mem_*                   : load request pulse (op, addr, ROB id)
//   rob_mem_*                   : committed store pulse (op, addr, data)
//   if_enable/if_addr           : fetch request level; if_ready/if_inst result
//   mem_busy                    : cannot accept a load/store this cycle
//   mem_data_ready/data/id      : load result broadcast pulse
//   mem_din/dout/a/wr           : RAM port, 1-cycle read latency
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter logic [XLEN-1:0] IO_ADDR = 32'h30000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      io_buffer_full,
    input  logic                      lsb_mem_enable,
    input  logic [INST_OP_WIDTH-1:0]  lsb_mem_op,
    input  logic [XLEN-1:0]           lsb_mem_addr,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id,
    input  logic                      rob_mem_enable,
    input  logic [INST_OP_WIDTH-1:0]  rob_mem_op,
    input  logic [XLEN-1:0]           rob_mem_addr,
    input  logic [XLEN-1:0]           rob_mem_data,
    input  logic                      if_enable,
    input  logic [XLEN-1:0]           if_addr,
    output logic                      if_ready,
    output logic [XLEN-1:0]           if_inst,
    output logic                      mem_busy,
    output logic                      mem_data_ready,
    output logic [XLEN-1:0]           mem_data,
    output logic [ROB_SIZE_WIDTH-1:0] mem_id,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [XLEN-1:0]           mem_a,
    output logic                      mem_wr
);

    mc_state_e                 state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [2:0]                len_q, len_d;
    logic [INST_OP_WIDTH-1:0]  op_q, op_d;
    logic [XLEN-1:0]           addr_q, addr_d;
    logic [XLEN-1:0]           data_q, data_d;
    logic [XLEN-1:0]           buf_q, buf_d;
    logic [ROB_SIZE_WIDTH-1:0] id_q, id_d;
    logic                      if_ready_q, if_ready_d;
    logic [XLEN-1:0]           if_inst_q, if_inst_d;
    logic                      mem_data_ready_q, mem_data_ready_d;
    logic [XLEN-1:0]           mem_data_q, mem_data_d;
    logic [ROB_SIZE_WIDTH-1:0] mem_id_q, mem_id_d;

    logic [XLEN-1:0]           word;
    logic [1:0]                lane;
    logic                      wr_c;

    function automatic logic io_hold(input logic [XLEN-1:0] a, input logic full);
        return full && (a == IO_ADDR || a == IO_ADDR + 32'd4);
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [INST_OP_WIDTH-1:0] op,
                                                   input logic [XLEN-1:0] w);
        case (op)
            OP_LB:   return {{24{w[7]}}, w[7:0]};
            OP_LBU:  return {24'b0, w[7:0]};
            OP_LH:   return {{16{w[15]}}, w[15:0]};
            OP_LHU:  return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign mem_busy       = (state_q != MC_IDLE) | lsb_mem_enable | rob_mem_enable;
    // A write strobe while the core is stalled would be replayed, so gate it.
    assign mem_wr         = wr_c & rdy;
    assign if_ready       = if_ready_q;
    assign if_inst        = if_inst_q;
    assign mem_data_ready = mem_data_ready_q;
    assign mem_data       = mem_data_q;
    assign mem_id         = mem_id_q;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        len_d            = len_q;
        op_d             = op_q;
        addr_d           = addr_q;
        data_d           = data_q;
        buf_d            = buf_q;
        id_d             = id_q;
        if_ready_d       = 1'b0;
        if_inst_d        = if_inst_q;
        mem_data_ready_d = 1'b0;
        mem_data_d       = mem_data_q;
        mem_id_d         = mem_id_q;
        mem_a            = '0;
        mem_dout         = 8'h00;
        wr_c             = 1'b0;
        // In LOAD/FETCH, cnt_q bytes have been addressed; mem_din now holds
        // byte cnt_q-1 because of the one-cycle read latency.
        lane             = cnt_q[1:0] - 2'd1;
        word             = buf_q;
        word[{lane, 3'b000} +: 8] = mem_din;

        unique case (state_q)
            MC_IDLE: begin
                if (rob_mem_enable) begin
                    op_d   = rob_mem_op;
                    addr_d = rob_mem_addr;
                    data_d = rob_mem_data;
                    len_d  = op_len(rob_mem_op);
                    if (io_hold(rob_mem_addr, io_buffer_full)) begin
                        state_d = MC_STORE;
                        cnt_d   = 3'd0;
                    end else begin
                        // Byte 0 goes out in the accept cycle itself.
                        mem_a    = rob_mem_addr;
                        mem_dout = rob_mem_data[7:0];
                        wr_c     = 1'b1;
                        cnt_d    = 3'd1;
                        state_d  = (op_len(rob_mem_op) == 3'd1) ? MC_IDLE : MC_STORE;
                    end
                end else if (lsb_mem_enable && !flush) begin
                    op_d    = lsb_mem_op;
                    addr_d  = lsb_mem_addr;
                    id_d    = lsb_mem_id;
                    len_d   = op_len(lsb_mem_op);
                    buf_d   = '0;
                    cnt_d   = 3'd1;
                    mem_a   = lsb_mem_addr;
                    state_d = MC_LOAD;
                end else if (if_enable && !flush) begin
                    addr_d  = if_addr;
                    len_d   = 3'd4;
                    buf_d   = '0;
                    cnt_d   = 3'd1;
                    mem_a   = if_addr;
                    state_d = MC_FETCH;
                end
            end
            MC_STORE: begin
                // Committed stores ignore flush; only the UART back-pressure stalls them.
                if (!io_hold(addr_q, io_buffer_full)) begin
                    mem_a    = addr_q + {{(XLEN-3){1'b0}}, cnt_q};
                    mem_dout = data_q[{cnt_q[1:0], 3'b000} +: 8];
                    wr_c     = 1'b1;
                    cnt_d    = cnt_q + 3'd1;
                    if (cnt_q + 3'd1 == len_q) state_d = MC_IDLE;
                end
            end
            MC_LOAD, MC_FETCH: begin
                if (flush) begin
                    state_d = MC_IDLE;
                end else begin
                    if (cnt_q < len_q) mem_a = addr_q + {{(XLEN-3){1'b0}}, cnt_q};
                    buf_d = word;
                    if (cnt_q == len_q) begin
                        state_d = MC_IDLE;
                        if (state_q == MC_LOAD) begin
                            mem_data_ready_d = 1'b1;
                            mem_data_d       = load_extend(op_q, word);
                            mem_id_d         = id_q;
                        end else begin
                            if_ready_d = 1'b1;
                            if_inst_d  = word;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= MC_IDLE;
            cnt_q            <= '0;
            len_q            <= '0;
            op_q             <= '0;
            addr_q           <= '0;
            data_q           <= '0;
            buf_q            <= '0;
            id_q             <= '0;
            if_ready_q       <= 1'b0;
            if_inst_q        <= '0;
            mem_data_ready_q <= 1'b0;
            mem_data_q       <= '0;
            mem_id_q         <= '0;
        end else if (rdy) begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            len_q            <= len_d;
            op_q             <= op_d;
            addr_q           <= addr_d;
            data_q           <= data_d;
            buf_q            <= buf_d;
            id_q             <= id_d;
            if_ready_q       <= if_ready_d;
            if_inst_q        <= if_inst_d;
            mem_data_ready_q <= mem_data_ready_d;
            mem_data_q       <= mem_data_d;
            mem_id_q         <= mem_id_d;
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller
//   Directed stimulus with a scoreboard: expected writes, load results and
//   fetch results are queued as requests are issued; a monitor pops and
//   compares whenever the DUT strobes mem_wr, mem_data_ready or if_ready.
module tb_memory_controller;
    import memory_controller_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      rdy = 1'b1;
    logic                      flush = 1'b0;
    logic                      io_buffer_full = 1'b0;
    logic                      lsb_mem_enable = 1'b0;
    logic [INST_OP_WIDTH-1:0]  lsb_mem_op = '0;
    logic [XLEN-1:0]           lsb_mem_addr = '0;
    logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id = '0;
    logic                      rob_mem_enable = 1'b0;
    logic [INST_OP_WIDTH-1:0]  rob_mem_op = '0;
    logic [XLEN-1:0]           rob_mem_addr = '0;
    logic [XLEN-1:0]           rob_mem_data = '0;
    logic                      if_enable = 1'b0;
    logic [XLEN-1:0]           if_addr = '0;
    logic                      if_ready;
    logic [XLEN-1:0]           if_inst;
    logic                      mem_busy;
    logic                      mem_data_ready;
    logic [XLEN-1:0]           mem_data;
    logic [ROB_SIZE_WIDTH-1:0] mem_id;
    logic [7:0]                mem_din = 8'h00;
    logic [7:0]                mem_dout;
    logic [XLEN-1:0]           mem_a;
    logic                      mem_wr;

    always #5 clk = ~clk;

    memory_controller dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
        .lsb_mem_enable(lsb_mem_enable), .lsb_mem_op(lsb_mem_op),
        .lsb_mem_addr(lsb_mem_addr), .lsb_mem_id(lsb_mem_id),
        .rob_mem_enable(rob_mem_enable), .rob_mem_op(rob_mem_op),
        .rob_mem_addr(rob_mem_addr), .rob_mem_data(rob_mem_data),
        .if_enable(if_enable), .if_addr(if_addr), .if_ready(if_ready), .if_inst(if_inst),
        .mem_busy(mem_busy), .mem_data_ready(mem_data_ready), .mem_data(mem_data),
        .mem_id(mem_id), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    // RAM model: one-cycle registered read, write on mem_wr.
    logic [7:0] ram [logic [31:0]];
    always @(posedge clk) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic [31:0] d; logic [ROB_SIZE_WIDTH-1:0] id; } ld_t;
    wr_t         exp_wr[$];
    ld_t         exp_ld[$];
    logic [31:0] exp_if[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: sampled well after the negedge where stimulus changes.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (mem_wr) begin
                if (exp_wr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: got a=0x%08h d=0x%02h expected none", mem_a, mem_dout);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", mem_a, w.a);
                    chk("wr_data", {24'b0, mem_dout}, {24'b0, w.d});
                end
            end
            if (mem_data_ready) begin
                if (exp_ld.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_load: got data=0x%08h expected no pulse", mem_data);
                end else begin
                    ld_t l;
                    l = exp_ld.pop_front();
                    chk("ld_data", mem_data, l.d);
                    chk("ld_id", {28'b0, mem_id}, {28'b0, l.id});
                end
            end
            if (if_ready) begin
                if (exp_if.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_fetch: got inst=0x%08h expected no pulse", if_inst);
                end else begin
                    chk("if_inst", if_inst, exp_if.pop_front());
                end
            end
        end
    end

    // Protocol watch: LSB and ROB must never request in the same cycle.
    always @(posedge clk) begin
        if (!rst && lsb_mem_enable && rob_mem_enable) begin
            checks++; failures++;
            $display("FAIL protocol: got simultaneous load and store expected exclusive");
        end
    end

    task automatic wait_idle();
        int n = 0;
        #1;
        while (mem_busy && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 40) begin
            checks++; failures++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
        @(negedge clk);
    endtask

    task automatic do_load(input logic [INST_OP_WIDTH-1:0] op, input logic [31:0] addr,
                           input logic [3:0] id, input logic [31:0] exp, input int n);
        int k;
        wait_idle();
        lsb_mem_enable = 1'b1; lsb_mem_op = op; lsb_mem_addr = addr; lsb_mem_id = id;
        exp_ld.push_back('{exp, id});
        @(negedge clk);
        lsb_mem_enable = 1'b0;
        #1;
        k = 1;
        while (!mem_data_ready && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk("load_latency", k, n + 1);
    endtask

    initial begin
        int k;
        ram[32'h1000] = 8'h78; ram[32'h1001] = 8'h56; ram[32'h1002] = 8'h34; ram[32'h1003] = 8'h12;
        ram[32'h1100] = 8'h80;
        ram[32'h1200] = 8'hFF; ram[32'h1201] = 8'h7F;
        ram[32'h1210] = 8'h00; ram[32'h1211] = 8'h80;
        ram[32'h0400] = 8'h13; ram[32'h0401] = 8'h05; ram[32'h0402] = 8'h00; ram[32'h0403] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", mem_busy, 0);
        chk("rst_ready", mem_data_ready, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_id", mem_id, 0);
        chk("rst_inst", if_inst, 0);
        chk("rst_a", mem_a, 0);
        chk("rst_wr", mem_wr, 0);

        // LW timing at 0x1000, id 5
        wait_idle();
        lsb_mem_enable = 1'b1; lsb_mem_op = OP_LW; lsb_mem_addr = 32'h1000; lsb_mem_id = 4'd5;
        exp_ld.push_back('{32'h12345678, 4'd5});
        #1;
        chk("lw_a0", mem_a, 32'h1000);
        chk("lw_busy0", mem_busy, 1);
        chk("lw_wr0", mem_wr, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            lsb_mem_enable = 1'b0;
            #1;
            if (i < 4) chk("lw_a", mem_a, 32'h1000 + i);
            chk("lw_busy", mem_busy, 1);
            chk("lw_no_ready", mem_data_ready, 0);
        end
        @(negedge clk); #1;
        chk("lw_busy5", mem_busy, 0);
        chk("lw_ready5", mem_data_ready, 1);

        // Extension cases
        do_load(OP_LB,  32'h1100, 4'd1, 32'hFFFFFF80, 1);
        do_load(OP_LBU, 32'h1100, 4'd2, 32'h00000080, 1);
        do_load(OP_LHU, 32'h1200, 4'd3, 32'h00007FFF, 2);
        do_load(OP_LH,  32'h1210, 4'd4, 32'hFFFF8000, 2);

        // SH 0xABCD1234 to 0x2002
        wait_idle();
        rob_mem_enable = 1'b1; rob_mem_op = OP_SH; rob_mem_addr = 32'h2002; rob_mem_data = 32'hABCD1234;
        exp_wr.push_back('{32'h2002, 8'h34});
        exp_wr.push_back('{32'h2003, 8'h12});
        #1;
        chk("sh_wr0", mem_wr, 1);
        chk("sh_a0", mem_a, 32'h2002);
        chk("sh_d0", {24'b0, mem_dout}, 32'h34);
        @(negedge clk); rob_mem_enable = 1'b0; #1;
        chk("sh_wr1", mem_wr, 1);
        chk("sh_a1", mem_a, 32'h2003);
        chk("sh_d1", {24'b0, mem_dout}, 32'h12);
        @(negedge clk); #1;
        chk("sh_wr2", mem_wr, 0);
        chk("sh_idle2", mem_busy, 0);

        // Store wins over a pending fetch; fetch follows
        wait_idle();
        if_enable = 1'b1; if_addr = 32'h0400;
        rob_mem_enable = 1'b1; rob_mem_op = OP_SW; rob_mem_addr = 32'h3000; rob_mem_data = 32'h11223344;
        exp_wr.push_back('{32'h3000, 8'h44});
        exp_wr.push_back('{32'h3001, 8'h33});
        exp_wr.push_back('{32'h3002, 8'h22});
        exp_wr.push_back('{32'h3003, 8'h11});
        exp_if.push_back(32'h00000513);
        #1;
        chk("arb_wr0", mem_wr, 1);
        chk("arb_a0", mem_a, 32'h3000);
        for (k = 1; k < 4; k++) begin
            @(negedge clk); rob_mem_enable = 1'b0; #1;
        end
        @(negedge clk); #1;
        chk("fetch_start_a", mem_a, 32'h0400);
        chk("fetch_start_wr", mem_wr, 0);
        k = 4;
        while (!if_ready && k < 30) begin
            @(negedge clk); #1; k++;
        end
        if_enable = 1'b0;
        chk("fetch_ready_cycle", k, 9);

        // Flush at t+2 of an LW aborts it silently
        wait_idle();
        lsb_mem_enable = 1'b1; lsb_mem_op = OP_LW; lsb_mem_addr = 32'h1000; lsb_mem_id = 4'd6;
        @(negedge clk); lsb_mem_enable = 1'b0;
        @(negedge clk); flush = 1'b1; #1;
        chk("flush_busy_t2", mem_busy, 1);
        @(negedge clk); flush = 1'b0; #1;
        chk("flush_idle_t3", mem_busy, 0);
        repeat (6) begin
            @(negedge clk); #1;
            chk("flush_no_ready", mem_data_ready, 0);
        end

        // Flush during SW does not stop the committed store
        wait_idle();
        rob_mem_enable = 1'b1; rob_mem_op = OP_SW; rob_mem_addr = 32'h2100; rob_mem_data = 32'hDEADBEEF;
        exp_wr.push_back('{32'h2100, 8'hEF});
        exp_wr.push_back('{32'h2101, 8'hBE});
        exp_wr.push_back('{32'h2102, 8'hAD});
        exp_wr.push_back('{32'h2103, 8'hDE});
        @(negedge clk); rob_mem_enable = 1'b0; flush = 1'b1; #1;
        chk("fsw_wr1", mem_wr, 1);
        chk("fsw_a1", mem_a, 32'h2101);
        @(negedge clk); #1;
        chk("fsw_wr2", mem_wr, 1);
        @(negedge clk); flush = 1'b0; #1;
        chk("fsw_wr3", mem_wr, 1);
        chk("fsw_a3", mem_a, 32'h2103);
        @(negedge clk); #1;
        chk("fsw_idle", mem_busy, 0);

        // SB to the IO port held by io_buffer_full for three cycles
        wait_idle();
        io_buffer_full = 1'b1;
        rob_mem_enable = 1'b1; rob_mem_op = OP_SB; rob_mem_addr = 32'h30000; rob_mem_data = 32'h00000041;
        exp_wr.push_back('{32'h30000, 8'h41});
        #1;
        chk("io_hold0", mem_wr, 0);
        @(negedge clk); rob_mem_enable = 1'b0; #1;
        chk("io_hold1", mem_wr, 0);
        @(negedge clk); #1;
        chk("io_hold2", mem_wr, 0);
        @(negedge clk); io_buffer_full = 1'b0; #1;
        chk("io_wr", mem_wr, 1);
        chk("io_a", mem_a, 32'h30000);
        chk("io_d", {24'b0, mem_dout}, 32'h41);
        @(negedge clk); #1;
        chk("io_idle", mem_busy, 0);

        repeat (3) @(negedge clk);
        chk("left_writes", exp_wr.size(), 0);
        chk("left_loads", exp_ld.size(), 0);
        chk("left_fetches", exp_if.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
Sole owner of the byte-wide RAM/IO port. It serialises three requesters onto that port:
- committed stores from the ROB;
- loads dequeued by the load/store buffer;
- 32-bit instruction fetches.

Load results are returned on the common mem_data broadcast (mem_data_ready/mem_data/mem_id), which the LSB, RS and ROB snoop. It sits directly downstream of the load/store buffer.

Parameters:
IO_ADDR, 32'h30000, byte address of the IO port; stores here are held while io_buffer_full.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low, all state holds
flush  in  1  mispredict flush
io_buffer_full  in  1  UART output buffer full
lsb_mem_enable  in  1  load request (one-cycle pulse)
lsb_mem_op  in  `INST_OP_WIDTH  LB/LH/LW/LBU/LHU
lsb_mem_addr  in  `XLEN  load byte address
lsb_mem_id  in  `ROB_SIZE_WIDTH  ROB id of the load
rob_mem_enable  in  1  committed-store request (one-cycle pulse)
rob_mem_op  in  `INST_OP_WIDTH  SB/SH/SW
rob_mem_addr  in  `XLEN  store byte address
rob_mem_data  in  `XLEN  store data; low bytes used
if_enable  in  1  fetch request; level, held until if_ready
if_addr  in  `XLEN  fetch address
if_ready  out  1  fetch done pulse
if_inst  out  `XLEN  fetched word
mem_busy  out  1  controller cannot accept a load/store this cycle
mem_data_ready  out  1  load result pulse
mem_data  out  `XLEN  extended load value
mem_id  out  `ROB_SIZE_WIDTH  ROB id of the result
mem_din  in  8  RAM read byte (1-cycle read latency)
mem_dout  out  8  RAM write byte
mem_a  out  `XLEN  RAM byte address
mem_wr  out  1  1 = write

Behaviour:
Reset and enable:
- rst sampled at posedge, priority over flush and requests.
- On reset: state IDLE, byte counter 0, if_ready/mem_data_ready 0, if_inst/mem_data 0, mem_id 0.
- rdy low freezes all registers.

States: IDLE, LOAD, STORE, FETCH.
- N = 1 for B/BU/SB, 2 for H/HU/SH, 4 for W/SW/fetch.
- mem_busy = (state != IDLE) | lsb_mem_enable | rob_mem_enable. Combinational, so back-to-back LSB pulses are impossible.

Accept, in IDLE only, priority store > load > fetch:
- Accept cycle t drives byte 0 combinationally: mem_a = addr, mem_wr = 1 for a store.
- A simultaneous load and store is a protocol violation; the bench asserts it never occurs.
- A fetch loses arbitration and stays pending (if_enable held).

LOAD / FETCH:
- Byte i address on mem_a at cycle t+i (i < N).
- mem_din sampled at the end of cycle t+i+1 into byte lane i (little-endian).
- At t+N+1: state returns IDLE, and either mem_data_ready = 1 (mem_data, mem_id) or if_ready = 1 (if_inst) pulses for one cycle.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- A new request can be accepted in cycle t+N+1.
- LW latency is 5 cycles after accept.

STORE:
- Cycles t..t+N-1: mem_wr = 1, mem_a = addr+i, mem_dout = data[8i+7:8i].
- Returns IDLE at t+N.
- No result broadcast.
- If addr is IO_ADDR or IO_ADDR+4 and io_buffer_full: hold in STORE with mem_wr = 0, counter frozen, until clear.

Idle outputs: mem_a = 0, mem_wr = 0, mem_dout = 0.

Addressing: addr+i computed in `XLEN with wrap; no alignment check.

flush:
- Aborts LOAD and FETCH: returns IDLE next cycle, and no ready pulse is emitted even if the final byte lands that cycle.
- STORE continues, because it is committed.
- In a flush cycle, lsb_mem_enable and if_enable are ignored; rob_mem_enable is still accepted.

Decomposition:
- Op encodings, `XLEN, `INST_OP_WIDTH and `ROB_SIZE_WIDTH stay in global_params.v.
- Add `MC_IDLE/`MC_LOAD/`MC_STORE/`MC_FETCH state codes there.
- No sub-module: byte-lane assembly and extension are a local function.

Test Plan:
- LW at 0x1000, RAM = 78 56 34 12, id 5 -> mem_a = 0x1000..0x1003 on t..t+3; at t+5 mem_data_ready = 1, mem_data = 0x12345678, mem_id = 5. mem_busy is high t..t+4 and low at t+5.
- LB from a 0x80 byte -> mem_data = 0xFFFFFF80. LBU from the same byte -> 0x00000080. LHU from 0xFF 0x7F -> 0x00007FFF.
- SH 0xABCD1234 to 0x2002 -> mem_wr = 1 at t, t+1 with (0x2002, 0x34), (0x2003, 0x12); no mem_data_ready; IDLE at t+2.
- if_enable held, plus a store accepted the same cycle -> store runs first; fetch starts the cycle after the store completes; if_ready 5 cycles later with the correct word.
- flush at t+2 of an LW -> no mem_data_ready pulse; IDLE at t+3. flush during an SW -> all 4 bytes still written.
- SB to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 those cycles; write occurs the first cycle after it clears.
